bp_fe_fetch_ctrl: RTL and testbench
===================================

BP_FE_FETCH_CTRL -- requirements
Module: bp_fe_fetch_ctrl

Interface
REQ-001 SHALL have parameter vaddr_width_p, default 39, meaning virtual address width.
REQ-002 SHALL have parameter instr_width_p, default 32, meaning instruction width.
REQ-003 SHALL have parameter reset_pc_p, default 'h0080000000, meaning first fetch PC after reset.
REQ-004 SHALL have ports (name direction width meaning):
- clk_i in 1 clock
- reset_i in 1 reset; synchronous, active-high
- redirect_v_i in 1 backend redirect strobe
- redirect_pc_i in vaddr_width_p redirect target
- fetch_v_o out 1 fetch command valid
- fetch_vaddr_o out vaddr_width_p fetch PC
- fetch_yumi_i in 1 fetch command accepted
- mem_poison_o out 1 kill in-flight fetches
- resp_v_i in 1 fetch response valid
- resp_data_i in instr_width_p instruction
- resp_icache_miss_i in 1 icache miss
- resp_itlb_miss_i in 1 ITLB miss
- resp_page_fault_i in 1 instruction page fault
- resp_access_fault_i in 1 instruction access fault
- fe_v_o out 1 queue entry valid
- fe_ready_i in 1 queue entry ready
- fe_pc_o out vaddr_width_p entry PC
- fe_instr_o out instr_width_p entry instruction
- fe_exc_o out 2 exception code: 0 none, 1 itlb_miss, 2 page_fault, 3 access_fault

Function
REQ-005 SHALL accept a fetch in cycle N (fetch_v_o & fetch_yumi_i) and expect its response, if any, exactly at cycle N+2; in-flight tracking is a 2-stage PC/valid shift pipe.
REQ-006 SHALL buffer responses in a 2-entry FIFO; fe_v_o = FIFO non-empty; pop on fe_v_o & fe_ready_i; head appears combinationally on fe_pc_o/fe_instr_o/fe_exc_o.
REQ-007 SHALL assert fetch_v_o only in state RUN, when no redirect is present, and when (FIFO free entries) > (in-flight count); an overflow is therefore impossible.
REQ-008 SHALL advance pc_r by 4 on each accepted fetch, modulo 2^vaddr_width_p.
REQ-009 SHALL implement states RUN, STALL. RUN->STALL on an enqueued exception response; STALL->RUN only on redirect_v_i.
REQ-010 On a response with icache_miss (and no itlb_miss), SHALL not enqueue, SHALL set pc_r to that response PC, SHALL assert mem_poison_o that cycle, SHALL clear the younger in-flight valid, and SHALL stay in RUN (replay).
REQ-011 On a response with a fault or miss, exception priority SHALL be itlb_miss > page_fault > access_fault; itlb_miss/page/access SHALL enqueue one entry with fe_instr_o = 0, SHALL assert mem_poison_o, and SHALL enter STALL.
REQ-012 On a response with no flags, SHALL enqueue {pc, data, 0}.
REQ-013 On redirect_v_i, SHALL set pc_r to redirect_pc_i, assert mem_poison_o, clear both in-flight valids, flush the FIFO, and drop any same-cycle response; redirect has priority over every other event.
REQ-014 A response arriving when the matching in-flight valid is clear SHALL be ignored.
REQ-015 mem_poison_o SHALL be combinational, asserted only in the cycle of redirect, replay, or exception enqueue.

Reset
REQ-016 While reset_i is high, SHALL drive pc_r = reset_pc_p, state = RUN, in-flight valids = 0, FIFO empty, fe_v_o = 0, fetch_v_o = 0, mem_poison_o = 0.
REQ-017 Assertion of reset_i mid-operation SHALL discard all in-flight and buffered entries; the first fetch SHALL issue the cycle after reset deasserts, at reset_pc_p.

Configuration
REQ-018 With BP_FE_FETCH_CTRL_PERF_EN defined, SHALL add 32-bit saturating counters perf_replay_o and perf_redirect_o (outputs, reset 0), incrementing on REQ-010 and REQ-013 events; without the macro, these ports and counters SHALL be absent and behaviour is otherwise identical.

Verification
REQ-019 Reset, fetch_yumi_i=1, clean responses at N+2, fe_ready_i=1 -> fe_pc_o sequence 0x80000000, 0x80000004, 0x80000008, fe_exc_o=0.
REQ-020 Response for 0x80000004 with icache_miss -> mem_poison_o=1 that cycle, no enqueue, next fetch_vaddr_o=0x80000004.
REQ-021 Response with itlb_miss and access_fault both set -> single entry fe_exc_o=1, fetch_v_o=0 until redirect to 0x80001000, then fetch_vaddr_o=0x80001000.
REQ-022 fe_ready_i=0 held -> at most 2 entries buffered, fetch_v_o deasserts, no entry lost or duplicated when ready returns.
REQ-023 redirect_v_i in the same cycle as resp_v_i with FIFO holding 1 entry -> fe_v_o=0 next cycle, response dropped, fetch_vaddr_o=redirect_pc_i.
REQ-024 pc_r=2^39-4 accepted -> next fetch_vaddr_o=0.

Source files
------------

// File: rtl/bp_fe_fetch_ctrl.sv
// Front-end fetch controller: issues fetch PCs, tracks a 2-deep in-flight pipe and buffers responses.
// Optional perf counters are enabled with `define BP_FE_FETCH_CTRL_PERF_EN.
module bp_fe_fetch_ctrl #(
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32,
    parameter logic [vaddr_width_p-1:0] reset_pc_p = 'h0080000000
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     redirect_v_i,
    input  logic [vaddr_width_p-1:0] redirect_pc_i,
    output logic                     fetch_v_o,
    output logic [vaddr_width_p-1:0] fetch_vaddr_o,
    input  logic                     fetch_yumi_i,
    output logic                     mem_poison_o,
    input  logic                     resp_v_i,
    input  logic [instr_width_p-1:0] resp_data_i,
    input  logic                     resp_icache_miss_i,
    input  logic                     resp_itlb_miss_i,
    input  logic                     resp_page_fault_i,
    input  logic                     resp_access_fault_i,
    output logic                     fe_v_o,
    input  logic                     fe_ready_i,
    output logic [vaddr_width_p-1:0] fe_pc_o,
    output logic [instr_width_p-1:0] fe_instr_o,
    output logic [1:0]               fe_exc_o
`ifdef BP_FE_FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]              perf_replay_o,
    output logic [31:0]              perf_redirect_o
`endif
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] STALL = 1'b1;

    logic [0:0]               state_q, state_d;
    logic [vaddr_width_p-1:0] pc_q, pc_d;
    logic                     s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic [vaddr_width_p-1:0] s1_pc_q, s2_pc_q;

    logic [vaddr_width_p-1:0] fifo_pc_q    [2];
    logic [instr_width_p-1:0] fifo_instr_q [2];
    logic [1:0]               fifo_exc_q   [2];
    logic                     rd_ptr_q, wr_ptr_q;
    logic [1:0]               count_q;

    logic       resp_hit, replay, exc_hit, clean_hit, accept, push, pop;
    logic [1:0] exc_code, inflight_cnt, free_cnt;

    // A response only counts if it lines up with the oldest live in-flight fetch.
    assign resp_hit  = resp_v_i & s2_v_q & ~redirect_v_i;
    assign replay    = resp_hit & resp_icache_miss_i & ~resp_itlb_miss_i;
    assign exc_hit   = resp_hit & ~replay
                     & (resp_itlb_miss_i | resp_page_fault_i | resp_access_fault_i);
    assign clean_hit = resp_hit & ~resp_icache_miss_i & ~resp_itlb_miss_i
                     & ~resp_page_fault_i & ~resp_access_fault_i;
    assign exc_code  = resp_itlb_miss_i  ? 2'd1 :
                       resp_page_fault_i ? 2'd2 : 2'd3;

    assign inflight_cnt = {1'b0, s1_v_q} + {1'b0, s2_v_q};
    assign free_cnt     = 2'd2 - count_q;

    // Credit check guarantees every outstanding response has a FIFO slot waiting for it.
    assign fetch_v_o     = ~reset_i & (state_q == RUN) & ~redirect_v_i & ~replay & ~exc_hit
                         & (free_cnt > inflight_cnt);
    assign fetch_vaddr_o = pc_q;
    assign accept        = fetch_v_o & fetch_yumi_i;
    assign mem_poison_o  = ~reset_i & (redirect_v_i | replay | exc_hit);

    assign fe_v_o     = ~reset_i & (count_q != 2'd0);
    assign fe_pc_o    = fifo_pc_q[rd_ptr_q];
    assign fe_instr_o = fifo_instr_q[rd_ptr_q];
    assign fe_exc_o   = fifo_exc_q[rd_ptr_q];

    assign push = exc_hit | clean_hit;
    assign pop  = fe_v_o & fe_ready_i;

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        s1_v_d  = accept;
        s2_v_d  = s1_v_q;
        if (accept) begin
            pc_d = pc_q + vaddr_width_p'(4);
        end
        if (redirect_v_i) begin
            pc_d    = redirect_pc_i;
            state_d = RUN;
            s1_v_d  = 1'b0;
            s2_v_d  = 1'b0;
        end else if (replay) begin
            pc_d   = s2_pc_q;
            s1_v_d = 1'b0;
            s2_v_d = 1'b0;
        end else if (exc_hit) begin
            state_d = STALL;
            s1_v_d  = 1'b0;
            s2_v_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q    <= reset_pc_p;
            state_q <= RUN;
            s1_v_q  <= 1'b0;
            s2_v_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            s1_v_q  <= s1_v_d;
            s2_v_q  <= s2_v_d;
        end
        s1_pc_q <= pc_q;
        s2_pc_q <= s1_pc_q;
    end

    // Redirect flushes the whole buffer, including anything being popped that cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i || redirect_v_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                fifo_pc_q[wr_ptr_q]    <= s2_pc_q;
                fifo_instr_q[wr_ptr_q] <= exc_hit ? '0 : resp_data_i;
                fifo_exc_q[wr_ptr_q]   <= exc_hit ? exc_code : 2'd0;
                wr_ptr_q               <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef BP_FE_FETCH_CTRL_PERF_EN
    logic [31:0] perf_replay_q, perf_redirect_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            perf_replay_q   <= '0;
            perf_redirect_q <= '0;
        end else begin
            if (replay && (perf_replay_q != '1)) begin
                perf_replay_q <= perf_replay_q + 32'd1;
            end
            if (redirect_v_i && (perf_redirect_q != '1)) begin
                perf_redirect_q <= perf_redirect_q + 32'd1;
            end
        end
    end

    assign perf_replay_o   = perf_replay_q;
    assign perf_redirect_o = perf_redirect_q;
`endif

endmodule

// File: tb/tb_bp_fe_fetch_ctrl.sv
// Randomized scoreboard bench for bp_fe_fetch_ctrl with a transaction-level reference model.
module tb_bp_fe_fetch_ctrl;

    localparam logic [38:0] RESET_PC = 39'h0080000000;
    localparam int          NUM_CYCLES = 3000;

    typedef struct packed {
        logic [38:0] pc;
        logic [31:0] instr;
        logic [1:0]  exc;
    } entry_t;

    typedef struct {
        logic [38:0] pc;
        int          cyc;
    } flight_t;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        redirect_v_i;
    logic [38:0] redirect_pc_i;
    logic        fetch_v_o;
    logic [38:0] fetch_vaddr_o;
    logic        fetch_yumi_i;
    logic        mem_poison_o;
    logic        resp_v_i;
    logic [31:0] resp_data_i;
    logic        resp_icache_miss_i, resp_itlb_miss_i, resp_page_fault_i, resp_access_fault_i;
    logic        fe_v_o;
    logic        fe_ready_i;
    logic [38:0] fe_pc_o;
    logic [31:0] fe_instr_o;
    logic [1:0]  fe_exc_o;
`ifdef BP_FE_FETCH_CTRL_PERF_EN
    logic [31:0] perfReplay, perfRedirect;
`endif

    int checks   = 0;
    int failures = 0;
    bit done     = 1'b0;

    // Reference model state: expected queue contents, in-flight fetches, PC and stall flag.
    entry_t      sbQ[$];
    flight_t     flights[$];
    logic [38:0] modelPc;
    bit          stalled;
    bit          pendFlush, pendPush;
    entry_t      pendEntry;

    // Memory responder schedule, indexed by the cycle the response is due.
    bit          schedV[4];
    logic [31:0] schedData[4];
    logic [3:0]  schedFlags[4];

    bp_fe_fetch_ctrl dut (
        .clk_i               (clk),
        .reset_i             (reset_i),
        .redirect_v_i        (redirect_v_i),
        .redirect_pc_i       (redirect_pc_i),
        .fetch_v_o           (fetch_v_o),
        .fetch_vaddr_o       (fetch_vaddr_o),
        .fetch_yumi_i        (fetch_yumi_i),
        .mem_poison_o        (mem_poison_o),
        .resp_v_i            (resp_v_i),
        .resp_data_i         (resp_data_i),
        .resp_icache_miss_i  (resp_icache_miss_i),
        .resp_itlb_miss_i    (resp_itlb_miss_i),
        .resp_page_fault_i   (resp_page_fault_i),
        .resp_access_fault_i (resp_access_fault_i),
        .fe_v_o              (fe_v_o),
        .fe_ready_i          (fe_ready_i),
        .fe_pc_o             (fe_pc_o),
        .fe_instr_o          (fe_instr_o),
        .fe_exc_o            (fe_exc_o)
`ifdef BP_FE_FETCH_CTRL_PERF_EN
        ,
        .perf_replay_o       (perfReplay),
        .perf_redirect_o     (perfRedirect)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    // Drive one cycle of inputs; the first stretch after reset is a clean streaming run.
    task automatic applyStimulus(input int t);
        bit          phase1;
        int          slot;
        int          r;
        logic [63:0] rnd;
        reset_i = (t < 3) || (t == 1500) || (t == 1501);
        phase1  = (t < 40) || (t >= 1502 && t < 1530);
        slot    = t % 4;

        redirect_v_i = 1'b0;
        r = int'($urandom_range(0, 99));
        if (!phase1 && !reset_i) redirect_v_i = stalled ? (r < 25) : (r < 3);
        r = int'($urandom_range(0, 3));
        rnd = {$urandom, $urandom};
        case (r)
            0:       redirect_pc_i = 39'h0080001000;
            1:       redirect_pc_i = 39'h0 - 39'(4 * $urandom_range(1, 4));
            default: redirect_pc_i = {rnd[38:2], 2'b00};
        endcase

        resp_v_i    = 1'b0;
        resp_data_i = $urandom;
        {resp_icache_miss_i, resp_itlb_miss_i, resp_page_fault_i, resp_access_fault_i} = 4'b0;
        if (schedV[slot]) begin
            resp_v_i    = 1'b1;
            resp_data_i = schedData[slot];
            {resp_icache_miss_i, resp_itlb_miss_i, resp_page_fault_i, resp_access_fault_i} = schedFlags[slot];
            schedV[slot] = 1'b0;
        end else if (!phase1 && $urandom_range(0, 19) == 0) begin
            resp_v_i = 1'b1;
            {resp_icache_miss_i, resp_itlb_miss_i, resp_page_fault_i, resp_access_fault_i} = 4'($urandom);
        end

        fetch_yumi_i = phase1 ? 1'b1 : ($urandom_range(0, 3) != 0);
        fe_ready_i   = phase1 ? 1'b1 : (((t / 64) % 4 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0));
    endtask

    // Predict this cycle's control outputs from the model, then advance the model.
    task automatic modelCycle(input int t);
        int       hitIdx;
        bit       hit, replay, exc, expFetchV, expPoison;
        logic [1:0] code;
        logic [3:0] flags;

        hitIdx = -1;
        foreach (flights[i]) if (flights[i].cyc == t - 2) hitIdx = i;
        hit    = !reset_i && !redirect_v_i && resp_v_i && (hitIdx >= 0);
        replay = hit && resp_icache_miss_i && !resp_itlb_miss_i;
        exc    = hit && !replay && (resp_itlb_miss_i || resp_page_fault_i || resp_access_fault_i);
        code   = resp_itlb_miss_i ? 2'd1 : (resp_page_fault_i ? 2'd2 : 2'd3);

        expPoison = !reset_i && (redirect_v_i || replay || exc);
        expFetchV = !reset_i && !stalled && !redirect_v_i && !replay && !exc
                    && ((2 - sbQ.size()) > flights.size());

        checkOutput("fetch_v", 64'(fetch_v_o), 64'(expFetchV));
        checkOutput("mem_poison", 64'(mem_poison_o), 64'(expPoison));
        if (expFetchV) checkOutput("fetch_vaddr", 64'(fetch_vaddr_o), 64'(modelPc));

        if (reset_i) begin
            flights.delete();
            modelPc   = RESET_PC;
            stalled   = 1'b0;
            pendFlush = 1'b1;
        end else if (redirect_v_i) begin
            flights.delete();
            modelPc   = redirect_pc_i;
            stalled   = 1'b0;
            pendFlush = 1'b1;
        end else begin
            if (replay) begin
                modelPc = flights[hitIdx].pc;
                flights.delete();
            end else if (exc) begin
                pendPush  = 1'b1;
                pendEntry = '{pc: flights[hitIdx].pc, instr: 32'h0, exc: code};
                stalled   = 1'b1;
                flights.delete();
            end else if (hit) begin
                pendPush  = 1'b1;
                pendEntry = '{pc: flights[hitIdx].pc, instr: resp_data_i, exc: 2'd0};
            end
            if (expFetchV && fetch_yumi_i) begin
                flights.push_back('{pc: modelPc, cyc: t});
                flags = 4'b0;
                if ((t >= 40 && t < 1500) || t >= 1530) begin
                    if ($urandom_range(0, 9) < 3) flags = 4'($urandom);
                end
                schedV[(t + 2) % 4]     = ($urandom_range(0, 19) != 0);
                schedData[(t + 2) % 4]  = $urandom;
                schedFlags[(t + 2) % 4] = flags;
                modelPc = modelPc + 39'd4;
            end
            for (int i = flights.size() - 1; i >= 0; i--) begin
                if (flights[i].cyc <= t - 2) flights.delete(i);
            end
        end
    endtask

    // Driver and model: the expected queue is only updated at the clock edge.
    initial begin
        reset_i = 1'b1;
        redirect_v_i = 1'b0;
        redirect_pc_i = '0;
        fetch_yumi_i = 1'b0;
        resp_v_i = 1'b0;
        resp_data_i = '0;
        {resp_icache_miss_i, resp_itlb_miss_i, resp_page_fault_i, resp_access_fault_i} = 4'b0;
        fe_ready_i = 1'b0;
        modelPc = RESET_PC;
        stalled = 1'b0;
        pendFlush = 1'b0;
        pendPush = 1'b0;
        foreach (schedV[i]) schedV[i] = 1'b0;
        for (int t = 0; t < NUM_CYCLES; t++) begin
            @(posedge clk);
            if (pendFlush) sbQ.delete();
            if (pendPush) sbQ.push_back(pendEntry);
            pendFlush = 1'b0;
            pendPush  = 1'b0;
            #1 applyStimulus(t);
            #2 modelCycle(t);
        end
        @(posedge clk);
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Monitor: pops and compares the queue head whenever the DUT hands off an entry.
    initial begin
        entry_t exp;
        bit     expFeV;
        forever begin
            @(negedge clk);
            if (!done && $time > 0) begin
                expFeV = !reset_i && (sbQ.size() != 0);
                checkOutput("fe_v", 64'(fe_v_o), 64'(expFeV));
                if (expFeV) begin
                    exp = sbQ[0];
                    checkOutput("fe_pc", 64'(fe_pc_o), 64'(exp.pc));
                    checkOutput("fe_instr", 64'(fe_instr_o), 64'(exp.instr));
                    checkOutput("fe_exc", 64'(fe_exc_o), 64'(exp.exc));
                    if (fe_ready_i) void'(sbQ.pop_front());
                end
            end
        end
    end

endmodule
